// File: rtl/wb_interconnect.sv
// wb_interconnect: shared-bus Wishbone interconnect for NUM_MASTERS masters and NUM_SLAVES slaves.
// The block provides round-robin arbitration, base/mask address decode and an internal error slave
// for unmapped addresses.
// Optional macro WB_IC_TIMEOUT_EN adds an ack timeout that error-terminates a stalled mapped access.
module wb_interconnect #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = {32'h30000080, 32'h30000000, 32'h38000000},
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = {32'hFFFFFFF0, 32'hFFFFFF80, 32'hFFC00000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS*DW-1:0]     m_dat_o,
  output logic [NUM_SLAVES-1:0]         s_cyc_o,
  output logic [NUM_SLAVES-1:0]         s_stb_o,
  output logic                          s_we_o,
  output logic [(DW/8)-1:0]             s_sel_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES*DW-1:0]      s_dat_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, arb_gnt;
  logic [MIW-1:0]         last_q, last_d, arb_idx, g_idx;
  logic [NUM_MASTERS-1:0] req;
  logic                   busy;
  logic                   g_cyc, g_stb, g_we;
  logic [SW-1:0]          g_sel;
  logic [AW-1:0]          g_adr;
  logic [DW-1:0]          g_dat;
  logic [NUM_SLAVES-1:0]  hit;
  logic                   mapped;
  logic                   slv_ack;
  logic [DW-1:0]          slv_dat;
  logic                   err_q;
  logic                   to_fire;
  logic                   ack_c, err_c;

  assign req     = m_cyc_i & m_stb_i;
  assign busy    = (state_q == BUSY);
  assign grant_o = gnt_q;

  // FSM state, current grant and round-robin pointer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= MIW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Round-robin pick: first requester scanning upward from last+1
  always_comb begin
    arb_gnt = '0;
    arb_idx = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      arb_idx = MIW'((32'(last_q) + k) % NUM_MASTERS);
      if (arb_gnt == '0 && req[arb_idx]) arb_gnt[arb_idx] = 1'b1;
    end
  end

  // Next-state: grant from IDLE, release to IDLE when the owner drops cyc
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = arb_gnt;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = g_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the granted master's request signals (all zero while nobody is granted)
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    g_idx = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (gnt_q[m]) begin
        g_cyc = m_cyc_i[m];
        g_stb = m_stb_i[m];
        g_we  = m_we_i[m];
        g_sel = m_sel_i[m*SW +: SW];
        g_adr = m_adr_i[m*AW +: AW];
        g_dat = m_dat_i[m*DW +: DW];
        g_idx = MIW'(m);
      end
    end
  end

  // Base/mask decode of the granted address; lowest slave index wins on overlap
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit == '0 && ((g_adr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]))
        hit[i] = 1'b1;
    end
  end

  assign mapped = |hit;

  // Return path from the decoded slave
  always_comb begin
    slv_ack = 1'b0;
    slv_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit[i]) begin
        slv_ack = s_ack_i[i];
        slv_dat = s_dat_i[i*DW +: DW];
      end
    end
  end

  // Default slave: one err pulse the cycle after an unmapped strobe, then re-arm
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) err_q <= 1'b0;
    else          err_q <= busy && !mapped && g_cyc && g_stb && !err_q;
  end

`ifdef WB_IC_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt_q;
  logic          stall_c;

  assign stall_c = busy && mapped && g_cyc && g_stb && !slv_ack;
  assign to_fire = stall_c && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Stall counter; restarts on ack, idle strobe, release or timeout
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !stall_c || to_fire) to_cnt_q <= '0;
    else                                 to_cnt_q <= to_cnt_q + CW'(1);
  end
`else
  logic unused_timeout;

  assign to_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Output routing: shared slave bus, per-slave strobes, per-master termination
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    ack_c   = 1'b0;
    err_c   = 1'b0;
    if (busy) begin
      s_we_o  = g_we;
      s_sel_o = g_sel;
      s_adr_o = g_adr;
      s_dat_o = g_dat;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (hit[i] && !to_fire) begin
          s_cyc_o[i] = g_cyc;
          s_stb_o[i] = g_stb;
        end
      end
      ack_c = mapped && slv_ack && g_cyc && g_stb && !to_fire;
      err_c = (err_q && !ack_c) || to_fire;
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        if (gnt_q[m]) begin
          m_ack_o[m] = ack_c;
          m_err_o[m] = err_c;
          if (ack_c) m_dat_o[m*DW +: DW] = slv_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// tb_wb_interconnect: cycle table for wb_interconnect plus a stalled-slave sequence.
module tb_wb_interconnect;

  localparam logic [31:0] A0 = 32'h38000010;  // slave 0
  localparam logic [31:0] A1 = 32'h30000084;  // slave 2
  localparam logic [31:0] AS = 32'h30000010;  // slave 1
  localparam logic [31:0] AU = 32'h20000000;  // unmapped
  localparam logic [31:0] D0 = 32'hCAFEF00D;
  localparam logic [31:0] D1 = 32'h11111111;
  localparam logic [31:0] D2 = 32'h22222222;
  localparam logic [31:0] MD0 = 32'hA0A0A0A0;
  localparam logic [31:0] MD1 = 32'h00000005;
  localparam int NV = 37;

  logic        clk, rst;
  logic [1:0]  req;
  logic [31:0] adr0, adr1;
  logic [2:0]  sack;
  logic [1:0]  m_ack, m_err, grant;
  logic [63:0] m_dat_o;
  logic [2:0]  s_cyc, s_stb;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;

  int n_checks = 0;
  int n_fail   = 0;

  wb_interconnect #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(req), .m_stb_i(req), .m_we_i(2'b10),
    .m_sel_i({4'hF, 4'h3}), .m_adr_i({adr1, adr0}), .m_dat_i({MD1, MD0}),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_ack_i(sack), .s_dat_i({D2, D1, D0}),
    .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [31:0] adr0, adr1;
    logic [2:0]  ack;
    logic [1:0]  e_gnt;
    logic [2:0]  e_stb;
    logic [1:0]  e_ack, e_err;
    logic [31:0] e_dat0, e_dat1;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(logic r, logic [1:0] q, logic [31:0] a0, logic [31:0] a1,
                              logic [2:0] k, logic [1:0] g, logic [2:0] s,
                              logic [1:0] ea, logic [1:0] ee, logic [31:0] d0, logic [31:0] d1);
    vec_t v;
    v.rst = r; v.req = q; v.adr0 = a0; v.adr1 = a1; v.ack = k;
    v.e_gnt = g; v.e_stb = s; v.e_ack = ea; v.e_err = ee; v.e_dat0 = d0; v.e_dat1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
    end
  endtask

  // Global bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_adr, e_dat;
    logic        e_we;
    logic [3:0]  e_sel;
    int          bad;

    //              rst req  adr0 adr1 ack     gnt    stb     ack    err    dat0 dat1
    vt[0]  = mk(0, 2'b00, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[1]  = mk(0, 2'b01, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[2]  = mk(0, 2'b01, A0, A1, 3'b000, 2'b01, 3'b001, 2'b00, 2'b00, 0,  0);
    vt[3]  = mk(0, 2'b01, A0, A1, 3'b001, 2'b01, 3'b001, 2'b01, 2'b00, D0, 0);
    vt[4]  = mk(0, 2'b00, A0, A1, 3'b000, 2'b01, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[5]  = mk(0, 2'b00, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[6]  = mk(0, 2'b10, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[7]  = mk(0, 2'b10, A0, A1, 3'b000, 2'b10, 3'b100, 2'b00, 2'b00, 0,  0);
    vt[8]  = mk(0, 2'b10, A0, A1, 3'b100, 2'b10, 3'b100, 2'b10, 2'b00, 0,  D2);
    vt[9]  = mk(0, 2'b00, A0, A1, 3'b000, 2'b10, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[10] = mk(0, 2'b00, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[11] = mk(0, 2'b11, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[12] = mk(0, 2'b11, A0, A1, 3'b001, 2'b01, 3'b001, 2'b01, 2'b00, D0, 0);
    vt[13] = mk(0, 2'b10, A0, A1, 3'b000, 2'b01, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[14] = mk(0, 2'b11, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[15] = mk(0, 2'b11, A0, A1, 3'b100, 2'b10, 3'b100, 2'b10, 2'b00, 0,  D2);
    vt[16] = mk(0, 2'b01, A0, A1, 3'b000, 2'b10, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[17] = mk(0, 2'b11, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[18] = mk(0, 2'b11, A0, A1, 3'b001, 2'b01, 3'b001, 2'b01, 2'b00, D0, 0);
    vt[19] = mk(0, 2'b10, A0, A1, 3'b000, 2'b01, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[20] = mk(0, 2'b10, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[21] = mk(0, 2'b10, A0, A1, 3'b100, 2'b10, 3'b100, 2'b10, 2'b00, 0,  D2);
    vt[22] = mk(0, 2'b00, A0, A1, 3'b000, 2'b10, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[23] = mk(0, 2'b00, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[24] = mk(0, 2'b01, AU, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[25] = mk(0, 2'b01, AU, A1, 3'b000, 2'b01, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[26] = mk(0, 2'b01, AU, A1, 3'b000, 2'b01, 3'b000, 2'b00, 2'b01, 0,  0);
    vt[27] = mk(0, 2'b00, AU, A1, 3'b000, 2'b01, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[28] = mk(0, 2'b00, A0, A1, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[29] = mk(0, 2'b10, A0, AS, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[30] = mk(0, 2'b10, A0, AS, 3'b000, 2'b10, 3'b010, 2'b00, 2'b00, 0,  0);
    vt[31] = mk(1, 2'b10, A0, AS, 3'b000, 2'b10, 3'b010, 2'b00, 2'b00, 0,  0);
    vt[32] = mk(0, 2'b11, A0, AS, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[33] = mk(0, 2'b11, A0, AS, 3'b001, 2'b01, 3'b001, 2'b01, 2'b00, D0, 0);
    vt[34] = mk(0, 2'b10, A0, AS, 3'b000, 2'b01, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[35] = mk(0, 2'b00, A0, AS, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);
    vt[36] = mk(0, 2'b00, A0, AS, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 0,  0);

    rst = 1'b1; req = '0; adr0 = A0; adr1 = A1; sack = '0;
    repeat (3) @(posedge clk);

    // Drive each row just after the edge, check it on the falling edge
    for (int n = 0; n < NV; n++) begin
      @(posedge clk);
      #1;
      rst = vt[n].rst; req = vt[n].req; adr0 = vt[n].adr0; adr1 = vt[n].adr1; sack = vt[n].ack;
      @(negedge clk);
      case (vt[n].e_gnt)
        2'b01:   begin e_adr = vt[n].adr0; e_we = 1'b0; e_sel = 4'h3; e_dat = MD0; end
        2'b10:   begin e_adr = vt[n].adr1; e_we = 1'b1; e_sel = 4'hF; e_dat = MD1; end
        default: begin e_adr = '0;         e_we = 1'b0; e_sel = 4'h0; e_dat = '0;  end
      endcase
      chk("grant",   n, 32'(grant),          32'(vt[n].e_gnt));
      chk("s_stb",   n, 32'(s_stb),          32'(vt[n].e_stb));
      chk("s_cyc",   n, 32'(s_cyc),          32'(vt[n].e_stb));
      chk("m_ack",   n, 32'(m_ack),          32'(vt[n].e_ack));
      chk("m_err",   n, 32'(m_err),          32'(vt[n].e_err));
      chk("m_dat0",  n, m_dat_o[31:0],       vt[n].e_dat0);
      chk("m_dat1",  n, m_dat_o[63:32],      vt[n].e_dat1);
      chk("s_adr",   n, s_adr,               e_adr);
      chk("s_we",    n, 32'(s_we),           32'(e_we));
      chk("s_sel",   n, 32'(s_sel),          32'(e_sel));
      chk("s_dat",   n, s_dat,               e_dat);
      chk("ack_err", n, 32'(m_ack & m_err),  32'd0);
    end

    // Slave 0 never acks: timeout (when enabled) or indefinite stall
    @(posedge clk);
    #1;
    req = 2'b01; adr0 = A0; sack = '0;
    @(negedge clk);
    chk("stall_idle", 0, 32'(grant), 32'd0);
`ifdef WB_IC_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("to_err", k, 32'(m_err), (k == 8) ? 32'd1 : 32'd0);
      chk("to_stb", k, 32'(s_stb), (k == 8) ? 32'd0 : 32'd1);
      chk("to_ack", k, 32'(m_ack), 32'd0);
    end
`else
    bad = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_err !== 2'b00 || s_stb !== 3'b001 || grant !== 2'b01) bad++;
    end
    chk("stall_no_err", 1000, 32'(bad), 32'd0);
`endif
    @(posedge clk);
    #1;
    req = 2'b00;
    @(negedge clk);
    chk("stall_drop_err", 0, 32'(m_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("stall_release", 0, 32'(grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
